// File: rtl/spi_serdes.sv
// spi_serdes: mode-0 SPI master shift engine (CPOL=0, CPHA=0), MSB first.
// Full duplex. Each transfer shifts out one word on mosi_out and shifts in one word from miso_in.
// All outputs come straight from registers.
module spi_serdes #(
    parameter int W       = 32,
    parameter int CLK_DIV = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] tx_data,
    input  logic         tx_start,
    output logic         tx_ready,
    output logic         rx_ready,
    output logic         spi_clk,
    output logic         mosi_out,
    input  logic         miso_in,
    output logic [W-1:0] rx_data,
    output logic         rx_dv
);

    localparam int HP_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BC_W = $clog2(W);
    localparam logic [HP_W-1:0] HP_LAST  = HP_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [HP_W-1:0] hp_cnt_q, hp_cnt_d;
    logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [W-1:0]    tx_shift_q, tx_shift_d;
    logic [W-1:0]    rx_shift_q, rx_shift_d;
    logic [W-1:0]    rx_data_q, rx_data_d;
    logic            ready_q, ready_d;
    logic            spi_clk_q, spi_clk_d;
    logic            mosi_q, mosi_d;
    logic            rx_dv_q, rx_dv_d;

    // Next-state and next-output logic for the IDLE/SHIFT sequencer.
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        hp_cnt_d   = hp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        ready_d    = ready_q;
        spi_clk_d  = spi_clk_q;
        mosi_d     = mosi_q;
        rx_dv_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d    = SHIFT;
                    ready_d    = 1'b0;
                    hp_cnt_d   = '0;
                    bit_cnt_d  = '0;
                    tx_shift_d = tx_data;
                    mosi_d     = tx_data[W-1];
                end
            end

            SHIFT: begin
                if (hp_cnt_q == HP_LAST) begin
                    hp_cnt_d  = '0;
                    spi_clk_d = ~spi_clk_q;
                    if (!spi_clk_q) begin
                        // Rising edge of spi_clk: capture the slave's bit.
                        rx_shift_d = {rx_shift_q[W-2:0], miso_in};
                    end else if (bit_cnt_q != BIT_LAST) begin
                        // Falling edge: move on to the next lower transmit bit.
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        tx_shift_d = tx_shift_q << 1;
                        mosi_d     = tx_shift_q[W-2];
                    end else begin
                        // Falling edge after the last bit: the word is complete.
                        state_d   = IDLE;
                        ready_d   = 1'b1;
                        mosi_d    = 1'b0;
                        rx_data_d = rx_shift_q;
                        rx_dv_d   = 1'b1;
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers. Reset returns everything to idle and aborts any transfer.
    // NOTE: non-blocking assignments, so every register samples values from before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            hp_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            ready_q    <= 1'b1;
            spi_clk_q  <= 1'b0;
            mosi_q     <= 1'b0;
            rx_dv_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hp_cnt_q   <= hp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            ready_q    <= ready_d;
            spi_clk_q  <= spi_clk_d;
            mosi_q     <= mosi_d;
            rx_dv_q    <= rx_dv_d;
        end
    end

    assign tx_ready = ready_q;
    assign rx_ready = ready_q;
    assign spi_clk  = spi_clk_q;
    assign mosi_out = mosi_q;
    assign rx_data  = rx_data_q;
    assign rx_dv    = rx_dv_q;

endmodule

// File: tb/tb_spi_serdes.sv
// tb_spi_serdes: directed bench for spi_serdes.
// Two instances are tested: the default one (W=32, CLK_DIV=2) and a small one (W=8, CLK_DIV=1).
// A cycle-count model predicts every output cycle by cycle.
// Directed checks with hand-computed literals pin the model down.
module tb_spi_serdes;

    localparam int W0 = 32;
    localparam int D0 = 2;
    localparam int W1 = 8;
    localparam int D1 = 1;
    localparam int NDUT = 2;

    typedef enum int {M_ZERO, M_LOOP, M_ONE, M_ALT} miso_mode_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] tx_data0;
    logic [7:0]  tx_data1;
    logic [1:0]  tx_start;
    logic [1:0]  tx_ready;
    logic [1:0]  rx_ready;
    logic [1:0]  spi_clk;
    logic [1:0]  mosi;
    logic [1:0]  miso;
    logic [1:0]  rx_dv;
    logic [31:0] rx_data0;
    logic [7:0]  rx_data1;
    miso_mode_t  mode0;
    miso_mode_t  mode1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_serdes #(.W(W0), .CLK_DIV(D0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data0),
        .tx_start (tx_start[0]),
        .tx_ready (tx_ready[0]),
        .rx_ready (rx_ready[0]),
        .spi_clk  (spi_clk[0]),
        .mosi_out (mosi[0]),
        .miso_in  (miso[0]),
        .rx_data  (rx_data0),
        .rx_dv    (rx_dv[0])
    );

    spi_serdes #(.W(W1), .CLK_DIV(D1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data1),
        .tx_start (tx_start[1]),
        .tx_ready (tx_ready[1]),
        .rx_ready (rx_ready[1]),
        .spi_clk  (spi_clk[1]),
        .mosi_out (mosi[1]),
        .miso_in  (miso[1]),
        .rx_data  (rx_data1),
        .rx_dv    (rx_dv[1])
    );

    // ---------------- model: elapsed cycles since the start was accepted ----------------
    logic        m_busy [NDUT];
    int          m_k    [NDUT];
    logic [31:0] m_tx   [NDUT];
    logic [31:0] m_acc  [NDUT];
    logic [31:0] m_rxd  [NDUT];
    logic        m_dv   [NDUT];

    function automatic int wid(input int i);
        return (i == 0) ? W0 : W1;
    endfunction

    function automatic int div(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    function automatic logic [31:0] tx_word(input int i);
        return (i == 0) ? tx_data0 : {24'h0, tx_data1};
    endfunction

    function automatic logic [31:0] rx_word(input int i);
        return (i == 0) ? rx_data0 : {24'h0, rx_data1};
    endfunction

    // miso source per instance: loopback, constant, or 1,0,1,0... per spi_clk period
    assign miso[0] = (mode0 == M_LOOP) ? mosi[0] :
                     (mode0 == M_ONE)  ? 1'b1 :
                     (mode0 == M_ALT)  ? (((m_k[0] / (2 * D0)) % 2) == 0) : 1'b0;
    assign miso[1] = (mode1 == M_LOOP) ? mosi[1] :
                     (mode1 == M_ONE)  ? 1'b1 :
                     (mode1 == M_ALT)  ? (((m_k[1] / (2 * D1)) % 2) == 0) : 1'b0;

    // Advance the model one clk; miso is captured D, 3D, 5D... cycles after acceptance.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NDUT; i++) begin
                m_busy[i] <= 1'b0;
                m_k[i]    <= 0;
                m_tx[i]   <= '0;
                m_acc[i]  <= '0;
                m_rxd[i]  <= '0;
                m_dv[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NDUT; i++) begin
                m_dv[i] <= 1'b0;
                if (!m_busy[i]) begin
                    if (tx_start[i]) begin
                        m_busy[i] <= 1'b1;
                        m_k[i]    <= 0;
                        m_tx[i]   <= tx_word(i);
                        m_acc[i]  <= '0;
                    end
                end else begin
                    if (((m_k[i] + 1) % (2 * div(i))) == div(i))
                        m_acc[i] <= {m_acc[i][30:0], miso[i]};
                    if (m_k[i] + 1 == 2 * div(i) * wid(i)) begin
                        m_busy[i] <= 1'b0;
                        m_dv[i]   <= 1'b1;
                        m_rxd[i]  <= m_acc[i];
                    end else begin
                        m_k[i] <= m_k[i] + 1;
                    end
                end
            end
        end
    end

    // {tx_ready, rx_ready, spi_clk, mosi, rx_dv, rx_data}
    function automatic logic [36:0] expect_vec(input int i);
        logic spi_e;
        logic mosi_e;
        int   d;
        d      = div(i);
        spi_e  = 1'b0;
        mosi_e = 1'b0;
        if (m_busy[i]) begin
            spi_e  = ((m_k[i] / d) % 2) == 1;
            mosi_e = m_tx[i][wid(i) - 1 - m_k[i] / (2 * d)];
        end
        return {!m_busy[i], !m_busy[i], spi_e, mosi_e, m_dv[i], m_rxd[i]};
    endfunction

    function automatic logic [36:0] dut_vec(input int i);
        return {tx_ready[i], rx_ready[i], spi_clk[i], mosi[i], rx_dv[i], rx_word(i)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare and monitors (on the falling edge) ----------------
    int          dv_total   [NDUT];
    int          low_total  [NDUT];
    logic [31:0] mosi_cap   [NDUT];
    int          since_rise [NDUT];
    int          rise_gap   [NDUT];
    int          since_dv   [NDUT];
    int          dv_gap     [NDUT];
    logic        prev_spi   [NDUT];

    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            prev_spi[i] <= spi_clk[i];
            if (rst) begin
                check($sformatf("cycle dut%0d", i), {27'h0, dut_vec(i)}, {27'h0, expect_vec(i)});
                if (!tx_ready[i])
                    low_total[i] <= low_total[i] + 1;
                if (rx_dv[i]) begin
                    dv_total[i] <= dv_total[i] + 1;
                    dv_gap[i]   <= since_dv[i];
                    since_dv[i] <= 1;
                end else begin
                    since_dv[i] <= since_dv[i] + 1;
                end
                if (spi_clk[i] && !prev_spi[i]) begin
                    mosi_cap[i]   <= {mosi_cap[i][30:0], mosi[i]};
                    rise_gap[i]   <= since_rise[i];
                    since_rise[i] <= 1;
                end else begin
                    since_rise[i] <= since_rise[i] + 1;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) sync();
    endtask

    task automatic set_data(input int i, input logic [31:0] d);
        if (i == 0) tx_data0 = d;
        else        tx_data1 = d[7:0];
    endtask

    task automatic wait_dv(input int i, input string name);
        int n;
        n = 0;
        while (!rx_dv[i] && n < 400) begin
            sync();
            n++;
        end
        check({name, " rx_dv seen"}, rx_dv[i], 1'b1);
    endtask

    // Pulse tx_start for one cycle with word d and return the monitor baselines.
    task automatic start(input int i, input logic [31:0] d, output int dv0, output int low0);
        dv0  = dv_total[i];
        low0 = low_total[i];
        set_data(i, d);
        tx_start[i] = 1'b1;
        sync();
        tx_start[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int dv0;
        int low0;
        logic [31:0] words [3];

        words[0] = 32'h0F0F0F0F;
        words[1] = 32'hC3C3C3C3;
        words[2] = 32'h00000001;
        tx_data0 = '0;
        tx_data1 = '0;
        tx_start = '0;
        mode0    = M_LOOP;
        mode1    = M_LOOP;
        rst      = 1'b0;

        // Reset values
        #12;
        check("reset dut0", {27'h0, dut_vec(0)}, {27'h0, 5'b11000, 32'h0});
        check("reset dut1", {27'h0, dut_vec(1)}, {27'h0, 5'b11000, 32'h0});
        sync();
        rst = 1'b1;
        idle(2);

        // Loopback, defaults, 0xA5A50F0F
        start(0, 32'hA5A50F0F, dv0, low0);
        wait_dv(0, "loop");
        check("loop ready-low cycles", low_total[0] - low0, 128);
        check("loop mosi word", mosi_cap[0], 32'hA5A50F0F);
        check("loop rx_data", rx_data0, 32'hA5A50F0F);
        check("loop spi_clk period", rise_gap[0], 4);
        idle(5);
        check("loop rx_dv count", dv_total[0] - dv0, 1);

        // miso held high, then alternating 1,0 per spi_clk period
        mode0 = M_ONE;
        start(0, 32'h00000000, dv0, low0);
        wait_dv(0, "ones");
        check("ones rx_data", rx_data0, 32'hFFFFFFFF);
        check("ones mosi word", mosi_cap[0], 32'h00000000);
        idle(2);
        mode0 = M_ALT;
        start(0, 32'h00000000, dv0, low0);
        wait_dv(0, "alt");
        check("alt rx_data", rx_data0, 32'hAAAAAAAA);
        idle(2);

        // Small instance: W=8, CLK_DIV=1, 0x81
        start(1, 32'h00000081, dv0, low0);
        wait_dv(1, "w8");
        check("w8 ready-low cycles", low_total[1] - low0, 16);
        check("w8 mosi sequence", mosi_cap[1][7:0], 8'h81);
        check("w8 spi_clk period", rise_gap[1], 2);
        check("w8 rx_data", rx_data1, 8'h81);
        idle(2);

        // tx_start re-asserted mid-transfer is ignored
        mode0 = M_LOOP;
        start(0, 32'h12345678, dv0, low0);
        idle(20);
        tx_data0    = 32'hFFFFFFFF;
        tx_start[0] = 1'b1;
        idle(3);
        tx_start[0] = 1'b0;
        wait_dv(0, "ignore");
        check("ignore rx_data", rx_data0, 32'h12345678);
        check("ignore mosi word", mosi_cap[0], 32'h12345678);
        check("ignore ready-low cycles", low_total[0] - low0, 128);
        idle(5);
        check("ignore rx_dv count", dv_total[0] - dv0, 1);

        // Reset at bit 10, then a clean transfer
        start(0, 32'hDEADBEEF, dv0, low0);
        idle(42);
        rst = 1'b0;
        #1;
        check("abort reset outputs", {27'h0, dut_vec(0)}, {27'h0, 5'b11000, 32'h0});
        idle(2);
        rst = 1'b1;
        idle(150);
        check("abort no rx_dv", dv_total[0] - dv0, 0);
        check("abort rx_data held 0", rx_data0, 32'h0);
        start(0, 32'h0000FFFF, dv0, low0);
        wait_dv(0, "after abort");
        check("after abort rx_data", rx_data0, 32'h0000FFFF);
        idle(5);
        check("after abort rx_dv count", dv_total[0] - dv0, 1);

        // tx_start held high: back-to-back words one idle cycle apart
        dv0         = dv_total[0];
        tx_data0    = words[0];
        tx_start[0] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            sync();
            wait_dv(0, "b2b");
            check($sformatf("b2b rx_data %0d", n), rx_data0, words[n]);
            if (n > 0)
                check($sformatf("b2b dv spacing %0d", n), dv_gap[0], 129);
            if (n < 2) tx_data0 = words[n + 1];
            else       tx_start[0] = 1'b0;
        end
        idle(10);
        check("b2b rx_dv count", dv_total[0] - dv0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
